// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst and lock protection.
// Grant moves only between bursts or after a lock is released.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HBURST,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic                           HMASTLOCK
);

  localparam int MIDX_W = $clog2(NUM_MASTERS);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [NUM_MASTERS-1:0] GRANT_RST =
    NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant;
  logic [MIDX_W-1:0]      r_master;
  logic                   r_mastlock;
  logic [3:0]             r_burst_rem;

  logic [MIDX_W-1:0]      w_gidx;
  logic [4:0]             w_len;
  logic [3:0]             w_rem_nxt;
  logic                   w_hold;
  logic [MIDX_W-1:0]      w_next_idx;
  logic                   w_found;
  logic [MIDX_W:0]        w_sum;
  logic [MIDX_W-1:0]      w_cand;

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) w_gidx = w_gidx | MIDX_W'(i);
    end
  end

  // INCR has no defined length, so it never protects the grant
  always_comb begin
    unique case (HBURST)
      3'b000:         w_len = 5'd1;
      3'b001:         w_len = 5'd0;
      3'b010, 3'b011: w_len = 5'd4;
      3'b100, 3'b101: w_len = 5'd8;
      default:        w_len = 5'd16;
    endcase
  end

  always_comb begin
    unique case (HTRANS)
      TR_NONSEQ: w_rem_nxt = (w_len <= 5'd1) ? 4'd0 : 4'(w_len - 5'd1);
      TR_SEQ:    w_rem_nxt = (r_burst_rem == 4'd0) ? 4'd0
                                                   : r_burst_rem - 4'd1;
      TR_BUSY:   w_rem_nxt = r_burst_rem;
      TR_IDLE:   w_rem_nxt = 4'd0;
      default:   w_rem_nxt = 4'd0;
    endcase
  end

  assign w_hold = HLOCK[w_gidx] | (w_rem_nxt > 4'd1);

  // Search starts just past the owner so it yields to any other requester
  always_comb begin
    w_next_idx = MIDX_W'(DEFAULT_MASTER);
    w_found    = 1'b0;
    w_sum      = '0;
    w_cand     = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_sum = {1'b0, w_gidx} + (MIDX_W+1)'(k);
      if (w_sum >= (MIDX_W+1)'(NUM_MASTERS))
        w_sum = w_sum - (MIDX_W+1)'(NUM_MASTERS);
      w_cand = w_sum[MIDX_W-1:0];
      if (!w_found && HBUSREQ[w_cand]) begin
        w_found    = 1'b1;
        w_next_idx = w_cand;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant     <= GRANT_RST;
      r_master    <= MIDX_W'(DEFAULT_MASTER);
      r_mastlock  <= 1'b0;
      r_burst_rem <= 4'd0;
    end else if (HREADY) begin
      r_master    <= w_gidx;
      r_mastlock  <= HLOCK[w_gidx];
      r_burst_rem <= w_rem_nxt;
      if (!w_hold)
        r_grant <= NUM_MASTERS'(1) << w_next_idx;
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter for the multi-master AHB interconnect. Samples master bus requests and lock requests, and drives one-hot `HGRANT`, the address-phase owner index `HMASTER` and `HMASTLOCK`. Tracks fixed-length bursts so ownership is never handed over mid-burst. Sits between the master request lines and the master-side address/write-data multiplexers, which select on `HMASTER`.

## Interface
- `NUM_MASTERS`, 4, number of requesting masters (matches `param_pkg::NUM_MASTERS`).
- `DEFAULT_MASTER`, 0, master granted after reset and when nobody requests.
- `MIDX_W`, `$clog2(NUM_MASTERS)`, width of the master index (derived, not overridden).

Ports:
- `HCLK` in 1: bus clock; all state updates on the rising edge.
- `HRESET` in 1: asynchronous, active-high reset.
- `HBUSREQ` in `NUM_MASTERS`: per-master bus request.
- `HLOCK` in `NUM_MASTERS`: per-master locked-transfer request.
- `HTRANS` in 2: transfer type of the current owner (muxed by `HMASTER`). Encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HBURST` in 3: burst type of the current owner.
- `HREADY` in 1: bus ready; the address phase is accepted when high.
- `HGRANT` out `NUM_MASTERS`: one-hot grant (registered).
- `HMASTER` out `MIDX_W`: index of the master owning the current address phase (registered).
- `HMASTLOCK` out 1: current address phase is locked (registered).

## Operation
- **Internal state**
  - `HGRANT`, `HMASTER`, `HMASTLOCK`.
  - `burst_rem`, 4 bits: remaining beats after the current accepted beat.
- **Burst length decode**
  - SINGLE = 1.
  - INCR = 0, meaning undefined length; re-arbitration is allowed every beat.
  - INCR4/WRAP4 = 4.
  - INCR8/WRAP8 = 8.
  - INCR16/WRAP16 = 16.
- **`burst_rem` next value (`rem_nxt`)**, evaluated only on an edge with `HREADY`=1:
  - NONSEQ: length−1, or 0 for SINGLE/INCR.
  - SEQ: `burst_rem`−1, saturating at 0.
  - BUSY: unchanged.
  - IDLE: 0. This covers early termination.
- **Hold condition**: `hold` = (`HLOCK[g]`=1, where g = index of `HGRANT`) OR (`rem_nxt` > 1).
- **Arbitration**
  - Applies on an edge with `HREADY`=1 and `hold`=0.
  - Search `HBUSREQ` starting at (g+1) mod `NUM_MASTERS`, wrapping, ending at g.
  - The first requester found becomes the new grant.
  - If no master requests, grant `DEFAULT_MASTER`.
  - This gives strict round-robin fairness: a continuously requesting current owner yields to any other requester.
- **Ownership handover**: on every edge with `HREADY`=1, `HMASTER` ← index(`HGRANT`) and `HMASTLOCK` ← `HLOCK[index(HGRANT)]`. Both use the pre-edge `HGRANT`.
- **Stall**: when `HREADY`=0, `HGRANT`, `HMASTER`, `HMASTLOCK` and `burst_rem` all hold.
- **Invariant**: `HGRANT` is always exactly one-hot.
- **Reset** (asynchronous, also mid-burst or mid-lock):
  - `HGRANT` = one-hot(`DEFAULT_MASTER`).
  - `HMASTER` = `DEFAULT_MASTER`.
  - `HMASTLOCK` = 0.
  - `burst_rem` = 0.

## Timing
- Request-to-grant latency: 1 cycle. `HBUSREQ` sampled at edge N with `HREADY`=1 and no hold gives `HGRANT` valid after edge N.
- Grant-to-ownership latency: ownership moves at the next `HREADY`=1 edge after the grant. `HMASTER` therefore lags `HGRANT` by exactly one accepted address phase.
- Fixed burst of length L:
  - The grant is held through the NONSEQ and the first L−3 SEQ beats.
  - The grant may move on the edge accepting beat L−1.
  - `HMASTER` changes on the edge accepting beat L.
  - The new owner's first address phase follows with no idle cycle.
- Lock has priority over burst counting.
  - The grant stays while the granted master holds `HLOCK`.
  - Once `HLOCK` deasserts, the first edge with `HREADY`=1 and `rem_nxt` ≤ 1 re-arbitrates.
- Simultaneous events:
  - New request plus last burst beat: the request is serviced by round robin.
  - `HRESET` overrides everything.
- Outputs change only on `HCLK` rising edges or on `HRESET` assertion.

## Test plan
- **Reset**: assert `HRESET` with `HBUSREQ`=4'b1111 → `HGRANT`=4'b0001, `HMASTER`=0, `HMASTLOCK`=0, held until release.
- **Round robin**: `HBUSREQ`=4'b1111, `HTRANS`=NONSEQ, `HBURST`=SINGLE, `HREADY`=1 → `HGRANT` cycles 0010, 0100, 1000, 0001. `HMASTER` follows one cycle later: 1, 2, 3, 0.
- **INCR4 protection**: master 1 owns the bus and issues NONSEQ, SEQ, SEQ, SEQ; master 2 requests throughout → `HGRANT`=0010 through beat 2. It switches to 0100 on the beat-3 edge, and `HMASTER`=2 after the beat-4 edge.
- **Stall**: mid-sequence, drive `HREADY`=0 for 3 cycles with changing `HBUSREQ` → `HGRANT`, `HMASTER` and `burst_rem` are frozen, then resume from their pre-stall values.
- **Lock**: master 3 granted with `HLOCK[3]`=1 while `HBUSREQ`=4'b0111 for 10 cycles → `HGRANT`=1000 and `HMASTLOCK`=1 throughout. Deassert `HLOCK[3]` → next grant is 0001.
- **Idle bus**: `HBUSREQ`=0 after master 2 owns → `HGRANT`=0001 on the next `HREADY` edge, `HMASTER`=0 one edge later. Repeat with `HRESET` asserted mid-INCR8 → outputs return to their reset values immediately.
